// File: rtl/bidir_bus_port_pkg.sv
// Shared definitions for the bidirectional bus port: FSM state encoding
// and the elaboration-time helpers that size the delay counter.
package bidir_bus_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_TURN  = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // The counter must hold the longest state duration without wrapping.
   function automatic int cnt_width(input int drv_hold, input int turn_cyc, input int cap_wait);
      return clog2(max3(drv_hold, turn_cyc, cap_wait + 1) + 1);
   endfunction

endpackage

// File: rtl/bidir_bus_port_delay_cnt.sv
// Loadable down-counter shared by every timed state of the bus port FSM;
// 'last' marks the final cycle of the loaded duration.
module port_delay_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/bidir_bus_port.sv
// Registered bidirectional port between the working register and the shared
// data bus: timed drive / turnaround / capture sequencing with status pulses.
module bidir_bus_port
   import bidir_bus_port_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int DRV_HOLD = 1,
   parameter int TURN_CYC = 1,
   parameter int CAP_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] from_wreg,
   inout  wire  [DATA_W-1:0] data,
   input  logic              mem_write,
   input  logic              mem_read,
   output logic [DATA_W-1:0] to_wreg,
   output logic              to_wreg_vld,
   output logic              busy,
   output logic              done,
   output logic              conflict,
   output logic              bus_oe
);

   localparam int CNT_W = cnt_width(DRV_HOLD, TURN_CYC, CAP_WAIT);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(DRV_HOLD);
   localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC);
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(CAP_WAIT + 1);

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] drv_q;
   logic              oe_d;
   logic              done_d;
   logic              conflict_d;
   logic              cap_d;
   logic              drv_load;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_last;

   assign busy = (state_q != ST_IDLE);

   port_delay_cnt #(
      .CNT_W(CNT_W)
   ) u_delay_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (cnt_load),
      .load_val(cnt_val),
      .en      (busy),
      .last    (cnt_last)
   );

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      oe_d       = 1'b0;
      done_d     = 1'b0;
      conflict_d = 1'b0;
      cap_d      = 1'b0;
      drv_load   = 1'b0;
      cnt_load   = 1'b0;
      cnt_val    = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (mem_read && mem_write) begin
               conflict_d = 1'b1;
            end else if (mem_read) begin
               state_d  = ST_DRIVE;
               oe_d     = 1'b1;
               drv_load = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = HOLD_LD;
            end else if (mem_write) begin
               state_d  = ST_WAIT;
               cnt_load = 1'b1;
               cnt_val  = WAIT_LD;
            end
         end
         ST_DRIVE: begin
            oe_d = 1'b1;
            if (cnt_last) begin
               oe_d = 1'b0;
               // A zero-length turnaround goes straight back to IDLE.
               if (TURN_CYC != 0) begin
                  state_d  = ST_TURN;
                  cnt_load = 1'b1;
                  cnt_val  = TURN_LD;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_TURN: begin
            if (cnt_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               cap_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bus_oe      <= 1'b0;
         drv_q       <= '0;
         to_wreg     <= '0;
         to_wreg_vld <= 1'b0;
         done        <= 1'b0;
         conflict    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_oe      <= oe_d;
         to_wreg_vld <= cap_d;
         done        <= done_d;
         conflict    <= conflict_d;
         if (drv_load) begin
            drv_q <= from_wreg;
         end
         if (cap_d) begin
            to_wreg <= data;
         end
      end
   end

   // Only registered values reach the bus, so from_wreg never glitches it.
   assign data = bus_oe ? drv_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bidir_bus_port.sv
// Scoreboard bench for bidir_bus_port: two instances (default parameters and
// DATA_W=8/DRV_HOLD=3/TURN_CYC=0/CAP_WAIT=0) against a cycle-timeline model.
module tb_bidir_bus_port;

   localparam int MAXC   = 4096;
   localparam int K_DRV  = 0;
   localparam int K_CAP  = 1;
   localparam int K_CONF = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic [15:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        mem_read  [2];
   logic        mem_write [2];
   logic [15:0] from_wreg [2];
   logic [15:0] tb_val    [2];
   logic        tb_oe     [2];

   wire [15:0] data0;
   wire [7:0]  data1;
   wire [15:0] to_wreg0;
   wire [7:0]  to_wreg1;
   wire        vld0, busy0, done0, conf0, oe0;
   wire        vld1, busy1, done1, conf1, oe1;

   assign data0 = tb_oe[0] ? tb_val[0]      : 16'hzzzz;
   assign data1 = tb_oe[1] ? tb_val[1][7:0] : 8'hzz;

   bidir_bus_port #(.DATA_W(16), .DRV_HOLD(1), .TURN_CYC(1), .CAP_WAIT(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .from_wreg(from_wreg[0]), .data(data0),
      .mem_write(mem_write[0]), .mem_read(mem_read[0]), .to_wreg(to_wreg0),
      .to_wreg_vld(vld0), .busy(busy0), .done(done0), .conflict(conf0), .bus_oe(oe0)
   );

   bidir_bus_port #(.DATA_W(8), .DRV_HOLD(3), .TURN_CYC(0), .CAP_WAIT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .from_wreg(from_wreg[1][7:0]), .data(data1),
      .mem_write(mem_write[1]), .mem_read(mem_read[1]), .to_wreg(to_wreg1),
      .to_wreg_vld(vld1), .busy(busy1), .done(done1), .conflict(conf1), .bus_oe(oe1)
   );

   // Observed status packed as {bus_oe, busy, done, conflict, to_wreg_vld}.
   logic [15:0] o_data [2];
   logic [15:0] o_wreg [2];
   logic [4:0]  o_st   [2];

   always_comb begin
      o_data[0] = data0;
      o_data[1] = {8'h00, data1};
      o_wreg[0] = to_wreg0;
      o_wreg[1] = {8'h00, to_wreg1};
      o_st[0]   = {oe0, busy0, done0, conf0, vld0};
      o_st[1]   = {oe1, busy1, done1, conf1, vld1};
   end

   function automatic int p_hold(input int i);
      return (i == 0) ? 1 : 3;
   endfunction
   function automatic int p_turn(input int i);
      return (i == 0) ? 1 : 0;
   endfunction
   function automatic int p_wait(input int i);
      return (i == 0) ? 2 : 0;
   endfunction
   function automatic logic [15:0] msk(input int i, input logic [15:0] v);
      return (i == 0) ? v : {8'h00, v[7:0]};
   endfunction

   // Reference timeline: expected status and bus value per cycle per instance.
   logic [4:0]  exp_st  [2][MAXC];
   logic [15:0] exp_dat [2][MAXC];
   exp_t        sb0[$];
   exp_t        sb1[$];
   int          ok [2];

   int          n_total = 0;
   int          n_bad   = 0;
   bit          chk_en  = 1'b0;
   bit          rst_chk = 1'b0;
   bit          end_req = 1'b0;
   bit          mon_done = 1'b0;
   logic [15:0] last_cap [2];
   logic [15:0] drv_seen [2];

   task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s inst%0d cyc=%0d: got %h, want %h", name, inst, cyc, act, req);
      end
   endtask

   // Monitor: compares every cycle; pops the scoreboard on done/conflict.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      int   kind_seen;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            if (rst_chk) check("reset_state", i, {11'h0, o_st[i], o_wreg[i]}, 32'h0);
            last_cap[i] = '0;
            if (i == 0) sb0.delete(); else sb1.delete();
         end else if (chk_en && cyc < MAXC) begin
            check("status", i, {27'h0, o_st[i]}, {27'h0, exp_st[i][cyc]});
            if (exp_st[i][cyc][4]) check("bus_data", i, {16'h0, o_data[i]}, {16'h0, exp_dat[i][cyc]});
            if (o_st[i][4] && tb_oe[i]) check("contention", i, 32'd1, 32'd0);
            if (o_st[i][4]) drv_seen[i] = o_data[i];
            if (o_st[i][2] || o_st[i][1]) begin
               have = 1'b0;
               if (i == 0) begin
                  if (sb0.size() > 0) begin have = 1'b1; e = sb0.pop_front(); end
               end else begin
                  if (sb1.size() > 0) begin have = 1'b1; e = sb1.pop_front(); end
               end
               check("sb_expected", i, {31'h0, have}, 32'd1);
               if (have) begin
                  kind_seen = o_st[i][1] ? K_CONF : (o_st[i][0] ? K_CAP : K_DRV);
                  check("sb_cycle", i, cyc, e.cyc);
                  check("sb_kind", i, kind_seen, e.kind);
                  if (e.kind == K_CAP) begin
                     check("capture_val", i, {16'h0, o_wreg[i]}, {16'h0, e.val});
                     last_cap[i] = e.val;
                  end else if (e.kind == K_DRV) begin
                     check("drive_val", i, {16'h0, drv_seen[i]}, {16'h0, e.val});
                  end
               end
            end
            check("to_wreg_hold", i, {16'h0, o_wreg[i]}, {16'h0, last_cap[i]});
         end
      end
      if (end_req && !mon_done) begin
         check("sb_drain", 0, sb0.size(), 0);
         check("sb_drain", 1, sb1.size(), 0);
         mon_done = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int i, input exp_t e);
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);
   endtask

   // Raise a request and record what the specification says must follow.
   task automatic start_op(input int i, input int kind, input logic [15:0] v_in, output int e0, output int d);
      logic [15:0] v;
      exp_t        e;
      v  = msk(i, v_in);
      e0 = (cyc + 1 > ok[i]) ? cyc + 1 : ok[i];
      if (kind == K_DRV) begin
         from_wreg[i] = v;
         mem_read[i]  = 1'b1;
         for (int c = e0; c < e0 + p_hold(i); c++) begin
            exp_st[i][c]  = 5'b11000;
            exp_dat[i][c] = v;
         end
         for (int c = e0 + p_hold(i); c < e0 + p_hold(i) + p_turn(i); c++) exp_st[i][c] = 5'b01000;
         d = e0 + p_hold(i) + p_turn(i);
         exp_st[i][d] = 5'b00100;
      end else if (kind == K_CAP) begin
         tb_val[i]    = v;
         mem_write[i] = 1'b1;
         for (int c = e0; c <= e0 + p_wait(i); c++) exp_st[i][c] = 5'b01000;
         d = e0 + p_wait(i) + 1;
         exp_st[i][d] = 5'b00101;
      end else begin
         mem_read[i]  = 1'b1;
         mem_write[i] = 1'b1;
         d = e0;
         exp_st[i][d] = 5'b00010;
      end
      ok[i] = d + 1;
      e.cyc  = d;
      e.kind = kind;
      e.val  = v;
      push_exp(i, e);
   endtask

   // Hold the request until done; scramble from_wreg after accept on drives.
   task automatic finish_op(input int i, input int kind, input int e0, input int d);
      while (cyc < d) begin
         tick();
         if (cyc >= e0 && cyc < d) begin
            if (kind == K_DRV) from_wreg[i] = 16'($urandom);
            if (kind == K_CAP) tb_oe[i] = 1'b1;
         end
      end
      mem_read[i]  = 1'b0;
      mem_write[i] = 1'b0;
      tb_oe[i]     = 1'b0;
   endtask

   task automatic run_op(input int i, input int kind, input logic [15:0] v);
      int e0;
      int d;
      start_op(i, kind, v, e0, d);
      finish_op(i, kind, e0, d);
   endtask

   task automatic random_ops(input int n);
      int i;
      int r;
      for (int k = 0; k < n; k++) begin
         i = int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         run_op(i, (r < 1) ? K_CONF : ((r < 5) ? K_DRV : K_CAP), 16'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      int e0;
      int d;
      int e0c;
      int dc;
      for (int i = 0; i < 2; i++) begin
         mem_read[i]  = 1'b0;
         mem_write[i] = 1'b0;
         from_wreg[i] = '0;
         tb_val[i]    = '0;
         tb_oe[i]     = 1'b0;
         last_cap[i]  = '0;
         drv_seen[i]  = '0;
         for (int c = 0; c < MAXC; c++) begin
            exp_st[i][c]  = '0;
            exp_dat[i][c] = '0;
         end
      end
      rst_n   = 1'b1;
      rst_chk = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      rst_chk = 1'b0;
      tick();
      ok[0]  = cyc + 1;
      ok[1]  = cyc + 1;
      chk_en = 1'b1;

      // Directed drive / capture / conflict on both configurations.
      run_op(0, K_DRV, 16'hA5C3);
      run_op(0, K_CAP, 16'h1234);
      tick();
      run_op(0, K_CONF, 16'h0);
      run_op(1, K_DRV, 16'h00A5);
      run_op(1, K_CAP, 16'h0034);
      tick();
      run_op(1, K_CONF, 16'h0);

      random_ops(40);

      // Capture requested while a drive is busy, held until accepted.
      for (int i = 0; i < 2; i++) begin
         tick();
         start_op(i, K_DRV, 16'hFFFF, e0, d);
         while (cyc < e0) tick();
         mem_read[i] = 1'b0;
         tick();
         start_op(i, K_CAP, 16'($urandom), e0c, dc);
         finish_op(i, K_CAP, e0c, dc);
      end

      // Asynchronous reset in the middle of a drive on both instances.
      tick();
      start_op(0, K_DRV, 16'h5A5A, e0, d);
      start_op(1, K_DRV, 16'h00C3, e0, d);
      tick();
      #1;
      chk_en  = 1'b0;
      rst_chk = 1'b1;
      rst_n   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_read[i] = 1'b0;
         for (int c = cyc; c < MAXC; c++) exp_st[i][c] = '0;
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rst_chk = 1'b0;
      tick();
      ok[0]  = cyc + 1;
      ok[1]  = cyc + 1;
      chk_en = 1'b1;

      random_ops(12);
      repeat (3) tick();

      end_req = 1'b1;
      for (int t = 0; t < 5 && !mon_done; t++) begin
         @(negedge clk);
         #1;
      end
      if (!mon_done) begin
         $display("FAIL monitor_drain: got no end-of-test check, want one");
         $fatal(1, "monitor did not finish");
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
